// File: rtl/colour_bbox_tracker.sv
// Passive stream monitor: accumulates the bounding box of colour-detected pixels
// over each video frame and registers it at end of frame for the overlay stage.
module colour_bbox_tracker #(
  parameter int IMAGE_W    = 640,
  parameter int IMAGE_H    = 480,
  parameter int COORD_W    = 11,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_beat,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [23:0]        in_data,
  input  logic               in_detect,
  output logic [COORD_W-1:0] bb_left,
  output logic [COORD_W-1:0] bb_right,
  output logic [COORD_W-1:0] bb_top,
  output logic [COORD_W-1:0] bb_bottom,
  output logic               bb_valid,
  output logic [CNT_W-1:0]   det_count,
  output logic               frame_done,
  output logic               overrun
);

  typedef enum logic [1:0] {WAIT_SOP, VIDEO, SKIP} state_e;

  localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(IMAGE_W);
  localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(IMAGE_H);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMAGE_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMAGE_H - 1);
  localparam logic [CNT_W-1:0]   MIN_P  = CNT_W'(MIN_PIXELS);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [COORD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] bb_left_q, bb_left_d, bb_right_q, bb_right_d;
  logic [COORD_W-1:0] bb_top_q, bb_top_d, bb_bottom_q, bb_bottom_d;
  logic               bb_valid_q, bb_valid_d;
  logic [CNT_W-1:0]   det_count_q, det_count_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;
  logic               commit;
  logic               data_unused;

  assign data_unused = ^in_data[23:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_SOP;
      x_q          <= '0;
      y_q          <= '0;
      min_x_q      <= X_LAST;
      min_y_q      <= Y_LAST;
      max_x_q      <= '0;
      max_y_q      <= '0;
      cnt_q        <= '0;
      bb_left_q    <= '0;
      bb_right_q   <= '0;
      bb_top_q     <= '0;
      bb_bottom_q  <= '0;
      bb_valid_q   <= 1'b0;
      det_count_q  <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      min_x_q      <= min_x_d;
      min_y_q      <= min_y_d;
      max_x_q      <= max_x_d;
      max_y_q      <= max_y_d;
      cnt_q        <= cnt_d;
      bb_left_q    <= bb_left_d;
      bb_right_q   <= bb_right_d;
      bb_top_q     <= bb_top_d;
      bb_bottom_q  <= bb_bottom_d;
      bb_valid_q   <= bb_valid_d;
      det_count_q  <= det_count_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    min_x_d      = min_x_q;
    min_y_d      = min_y_q;
    max_x_d      = max_x_q;
    max_y_d      = max_y_q;
    cnt_d        = cnt_q;
    bb_left_d    = bb_left_q;
    bb_right_d   = bb_right_q;
    bb_top_d     = bb_top_q;
    bb_bottom_d  = bb_bottom_q;
    bb_valid_d   = bb_valid_q;
    det_count_d  = det_count_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    commit       = 1'b0;

    if (in_beat) begin
      if (in_sop) begin
        // A sop restarts from any state; an unterminated packet is simply dropped.
        x_d     = '0;
        y_d     = '0;
        min_x_d = X_LAST;
        min_y_d = Y_LAST;
        max_x_d = '0;
        max_y_d = '0;
        cnt_d   = '0;
        if (in_data[3:0] == 4'd0) begin
          state_d = in_eop ? WAIT_SOP : VIDEO;
          commit  = in_eop;
        end else begin
          state_d = in_eop ? WAIT_SOP : SKIP;
        end
      end else if (state_q == VIDEO) begin
        if (y_q < Y_LIM && x_q < X_LIM) begin
          if (in_detect) begin
            if (x_q < min_x_q) min_x_d = x_q;
            if (x_q > max_x_q) max_x_d = x_q;
            if (y_q < min_y_q) min_y_d = y_q;
            if (y_q > max_y_q) max_y_d = y_q;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          overrun_d = 1'b1;
        end
        if (in_eop) begin
          commit  = 1'b1;
          state_d = WAIT_SOP;
        end
      end else if (state_q == SKIP && in_eop) begin
        state_d = WAIT_SOP;
      end
    end

    // Commit sees the eop pixel's contribution via the _d accumulators.
    if (commit) begin
      frame_done_d = 1'b1;
      det_count_d  = cnt_d;
      if (cnt_d >= MIN_P && cnt_d != '0) begin
        bb_left_d   = min_x_d;
        bb_right_d  = max_x_d;
        bb_top_d    = min_y_d;
        bb_bottom_d = max_y_d;
        bb_valid_d  = 1'b1;
      end else begin
        bb_valid_d  = 1'b0;
      end
    end
  end

  always_comb begin
    bb_left    = bb_left_q;
    bb_right   = bb_right_q;
    bb_top     = bb_top_q;
    bb_bottom  = bb_bottom_q;
    bb_valid   = bb_valid_q;
    det_count  = det_count_q;
    frame_done = frame_done_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_colour_bbox_tracker.sv
// Directed bench for colour_bbox_tracker on an 8x4 image; expected frame
// results are queued at stimulus time and compared on each frame_done pulse.
module tb_colour_bbox_tracker;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int MINP  = 2;
  localparam int CW    = 11;
  localparam int CNTW  = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_beat, in_sop, in_eop, in_detect;
  logic [23:0]     in_data;
  logic [CW-1:0]   bb_left, bb_right, bb_top, bb_bottom;
  logic            bb_valid;
  logic [CNTW-1:0] det_count;
  logic            frame_done, overrun;

  colour_bbox_tracker #(
    .IMAGE_W(W), .IMAGE_H(H), .COORD_W(CW), .MIN_PIXELS(MINP), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .in_beat(in_beat), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_detect(in_detect), .bb_left(bb_left), .bb_right(bb_right),
    .bb_top(bb_top), .bb_bottom(bb_bottom), .bb_valid(bb_valid), .det_count(det_count),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]   l, r, t, b;
    logic            v;
    logic [CNTW-1:0] c;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  bit            det_pix[64];
  bit            gaps = 1'b0;
  logic [CW-1:0] m_l = '0, m_r = '0, m_t = '0, m_b = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && frame_done) begin
      if (sb.size() == 0) begin
        check("unexpected_frame_done", 32'(frame_done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("det_count", 32'(det_count), 32'(e.c));
        check("bb_valid", 32'(bb_valid), 32'(e.v));
        check("bb_left", 32'(bb_left), 32'(e.l));
        check("bb_right", 32'(bb_right), 32'(e.r));
        check("bb_top", 32'(bb_top), 32'(e.t));
        check("bb_bottom", 32'(bb_bottom), 32'(e.b));
      end
    end
  end

  task automatic beat(input logic sop, input logic eop, input logic [23:0] data, input logic det);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_sop = 1'($urandom); in_eop = 1'($urandom);
        in_detect = 1'($urandom); in_data = 24'($urandom);
        @(posedge clk); #1;
      end
    end
    in_beat = 1'b1; in_sop = sop; in_eop = eop; in_data = data; in_detect = det;
    @(posedge clk); #1;
    in_beat = 1'b0;
  endtask

  task automatic clear_det();
    for (int i = 0; i < 64; i++) det_pix[i] = 1'b0;
  endtask

  task automatic send_video(input int npix);
    exp_t e;
    int cnt;
    int mnx, mxx, mny, mxy;
    cnt = 0; mnx = W - 1; mny = H - 1; mxx = 0; mxy = 0;
    for (int i = 0; i < npix && i < W * H; i++) begin
      if (det_pix[i]) begin
        cnt++;
        if (i % W < mnx) mnx = i % W;
        if (i % W > mxx) mxx = i % W;
        if (i / W < mny) mny = i / W;
        if (i / W > mxy) mxy = i / W;
      end
    end
    if (cnt >= MINP) begin
      m_l = CW'(mnx); m_r = CW'(mxx); m_t = CW'(mny); m_b = CW'(mxy);
    end
    e.l = m_l; e.r = m_r; e.t = m_t; e.b = m_b;
    e.v = (cnt >= MINP); e.c = CNTW'(cnt);
    sb.push_back(e);
    beat(1'b1, npix == 0, 24'h5A5A50, 1'b1);
    for (int i = 0; i < npix; i++) beat(1'b0, i == npix - 1, 24'($urandom), det_pix[i]);
  endtask

  task automatic send_partial(input int npix);
    beat(1'b1, 1'b0, 24'h000000, 1'b0);
    for (int i = 0; i < npix; i++) beat(1'b0, 1'b0, 24'($urandom), det_pix[i]);
  endtask

  task automatic send_other(input int nwords);
    beat(1'b1, 1'b0, 24'h00000F, 1'b1);
    for (int i = 0; i < nwords; i++) beat(1'b0, i == nwords - 1, 24'($urandom), 1'b1);
  endtask

  task automatic t1_pattern();
    clear_det();
    det_pix[1*W+2] = 1'b1; det_pix[1*W+5] = 1'b1; det_pix[3*W+3] = 1'b1;
    send_video(W * H);
  endtask

  initial begin
    int waited;
    reset = 1'b1; in_beat = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = '0; in_detect = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_bb_left", 32'(bb_left), 32'd0);
    check("rst_bb_right", 32'(bb_right), 32'd0);
    check("rst_bb_top", 32'(bb_top), 32'd0);
    check("rst_bb_bottom", 32'(bb_bottom), 32'd0);
    check("rst_bb_valid", 32'(bb_valid), 32'd0);
    check("rst_det_count", 32'(det_count), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // three detects -> valid box 2,5,1,3
    t1_pattern();
    // single detect -> below threshold, box held
    clear_det(); det_pix[2*W+4] = 1'b1;
    send_video(W * H);
    // non-video packet full of detects, then empty video frame
    send_other(12);
    clear_det();
    send_video(W * H);
    // descriptor-only video packet commits an empty frame
    send_video(0);
    // interrupted frame followed by corner detects
    for (int i = 0; i < 64; i++) det_pix[i] = 1'b1;
    send_partial(10);
    clear_det(); det_pix[0] = 1'b1; det_pix[3*W+7] = 1'b1;
    send_video(W * H);
    // overlong frame: extra detect pixels must be excluded
    clear_det(); det_pix[1] = 1'b1; det_pix[2*W+6] = 1'b1;
    for (int i = W * H; i < 40; i++) det_pix[i] = 1'b1;
    send_video(40);
    check("overrun_set", 32'(overrun), 32'd1);
    t1_pattern();
    repeat (2) @(posedge clk); #1;
    check("overrun_sticky", 32'(overrun), 32'd1);

    // reset mid-frame
    clear_det();
    for (int i = 0; i < 5; i++) det_pix[i * 2] = 1'b1;
    send_partial(12);
    reset = 1'b1;
    #2;
    check("midrst_bb_valid", 32'(bb_valid), 32'd0);
    check("midrst_det_count", 32'(det_count), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    m_l = '0; m_r = '0; m_t = '0; m_b = '0;
    clear_det();
    send_video(W * H);

    // gapped stimulus must give identical results
    gaps = 1'b1;
    t1_pattern();
    clear_det(); det_pix[2*W+4] = 1'b1;
    send_video(W * H);
    gaps = 1'b0;

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/colour_bbox_tracker.md
Name: colour_bbox_tracker

Overview:
- Streaming monitor that sits directly upstream of the vision highlight/overlay stage.
- Taps the accepted pixel stream together with the per-pixel colour-detect bit.
- Tracks raster position and accumulates the min/max x/y of detected pixels over one video frame.
- At end of frame, registers the bounding box (left/right/top/bottom) that the overlay stage draws on the next frame.
- Passive: never back-pressures the stream.

Parameters:
- IMAGE_W, 640, active pixels per line.
- IMAGE_H, 480, active lines per frame.
- COORD_W, 11, width of x/y coordinates and box outputs.
- MIN_PIXELS, 16, minimum detected-pixel count for a frame's box to be declared valid.
- CNT_W, 20, width of the detected-pixel counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_beat  in  1  stream word accepted this cycle (valid & ready of the tapped link).
- in_sop  in  1  start-of-packet; qualified by in_beat.
- in_eop  in  1  end-of-packet; qualified by in_beat.
- in_data  in  24  stream word; on the sop word, in_data[3:0] is the packet type (0 = video).
- in_detect  in  1  colour-detect result for this pixel; ignored on the sop word.
- bb_left  out  COORD_W  min x of the last valid frame.
- bb_right  out  COORD_W  max x of the last valid frame.
- bb_top  out  COORD_W  min y of the last valid frame.
- bb_bottom  out  COORD_W  max y of the last valid frame.
- bb_valid  out  1  last completed video frame met MIN_PIXELS.
- det_count  out  CNT_W  detected pixels in the last completed video frame.
- frame_done  out  1  one-cycle pulse when a video frame completes.
- overrun  out  1  sticky: a frame carried more than IMAGE_W*IMAGE_H pixels.

Behaviour:
- Reset (async, active-high): state=WAIT_SOP; x=y=0; all bb_* = 0; bb_valid=0; det_count=0; frame_done=0; overrun=0. Running accumulators: min_x=IMAGE_W-1, min_y=IMAGE_H-1, max_x=max_y=0, cnt=0.
- Only cycles with in_beat=1 advance anything. in_sop/in_eop/in_data/in_detect are don't-care otherwise.
- States: WAIT_SOP, VIDEO, SKIP.
- WAIT_SOP:
  - sop beat with type 0: clear accumulators and x,y, then go to VIDEO.
  - sop beat with type != 0: go to SKIP.
  - Non-sop beat: ignored.
- VIDEO, pixel beat (sop=0):
  - If in_detect=1 and x<IMAGE_W and y<IMAGE_H: min_x=min(min_x,x), max_x=max(max_x,x), likewise for y; cnt increments, saturating at 2^CNT_W-1.
  - Raster advance: x increments; when x==IMAGE_W-1, x wraps to 0 and y increments.
  - Once y reaches IMAGE_H: further pixels are ignored for accumulation and overrun is set (sticky until reset).
- VIDEO, eop beat: the eop pixel is processed normally first, then the frame is committed. Next state is WAIT_SOP.
- SKIP: stays until an eop beat, then goes to WAIT_SOP.
- sop beat while in VIDEO or SKIP (missing eop): abandon the current packet with no commit and no frame_done. Treat the beat exactly as a sop in WAIT_SOP.
- sop and eop on the same beat (descriptor-only packet):
  - Video type: commit an empty frame.
  - Otherwise: return to WAIT_SOP.
- Commit (registered on the edge ending the eop beat; outputs visible next cycle, latency 1):
  - frame_done=1 for exactly one cycle; det_count=cnt.
  - If cnt>=MIN_PIXELS: bb_left=min_x, bb_right=max_x, bb_top=min_y, bb_bottom=max_y, bb_valid=1.
  - Otherwise: bb_valid=0 and bb_* hold their previous values.
- Short frame (eop before IMAGE_W*IMAGE_H pixels): commit normally with whatever was accumulated.
- Output invariant: whenever bb_valid=1, bb_left<=bb_right and bb_top<=bb_bottom.
- Reset asserted mid-frame: all state clears immediately; the partial frame is never committed.

Test Plan:
- Reset, then a video frame of IMAGE_W=8, IMAGE_H=4 (test parameters, MIN_PIXELS=2) with detect at (2,1),(5,1),(3,3) -> one cycle after eop: left=2, right=5, top=1, bottom=3, det_count=3, bb_valid=1, frame_done a single 1-cycle pulse.
- Same geometry, detect only at (4,2) -> det_count=1, bb_valid=0, bb_* keep the previous frame's values (2,5,1,3).
- Non-video packet (type 0xF) carrying detect=1 on every word, followed by a video frame with no detects -> no frame_done for the non-video packet; the video frame gives det_count=0, bb_valid=0.
- Video frame interrupted by a new video sop after 10 pixels, then a complete frame with detect at (0,0),(7,3) -> single frame_done; box 0,7,0,3.
- Frame with 40 pixel beats (32 expected), extra pixels all detect=1 -> overrun=1 and stays set; box excludes the extra pixels; a subsequent normal frame commits correctly.
- Assert reset in the middle of a frame with 5 detects, then send a full frame with none -> bb_valid=0, det_count=0, bb_*=0; in_beat held low for random gaps between beats -> results are identical.
